// File: rtl/game_state_ctrl_if.sv
// Button, collision and display-path signals of the game controller.
// The testbench (or the upstream integration) holds the master side.
interface game_state_ctrl_if;
  logic       game_tick;
  logic       start_btn;
  logic       jump_btn;
  logic       hit;
  logic [9:0] distance;
  logic [9:0] obj_counter;
  logic       menuScreen;
  logic       playerWon;
  logic       playerLost;
  logic [1:0] lives_left;

  modport master (
    output game_tick, start_btn, jump_btn, hit,
    input  distance, obj_counter, menuScreen, playerWon, playerLost, lives_left
  );

  modport slave (
    input  game_tick, start_btn, jump_btn, hit,
    output distance, obj_counter, menuScreen, playerWon, playerLost, lives_left
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game FSM (menu/play/won/lost), jump physics and obstacle scroll feeding the video stage.
// Define GAME_LIVES_EN to enable the multi-life mode; otherwise any hit in play ends the game.
module game_state_ctrl #(
  parameter int JUMP_HEIGHT = 80,
  parameter int JUMP_STEP   = 4,
  parameter int SCROLL_STEP = 2,
  parameter int SCROLL_WRAP = 800,
  parameter int WIN_LAPS    = 3,
  parameter int LIVES       = 3
) (
  input  logic              clk,
  input  logic              reset,
  game_state_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {ST_MENU, ST_PLAY, ST_WON, ST_LOST} state_e;
  typedef enum logic [1:0] {J_IDLE, J_UP, J_DOWN} jump_e;

  localparam int          LAPS_W        = (WIN_LAPS < 2) ? 1 : $clog2(WIN_LAPS + 1);
  localparam logic [10:0] JUMP_HEIGHT_W = 11'(JUMP_HEIGHT);
  localparam logic [10:0] JUMP_STEP_W   = 11'(JUMP_STEP);
  localparam logic [10:0] SCROLL_STEP_W = 11'(SCROLL_STEP);
  localparam logic [10:0] SCROLL_WRAP_W = 11'(SCROLL_WRAP);

  state_e              state_q, state_d;
  jump_e               jump_q, jump_d;
  logic [9:0]          distance_q, distance_d;
  logic [9:0]          obj_counter_q, obj_counter_d;
  logic [LAPS_W-1:0]   laps_q, laps_d;
  logic                jump_req_q, jump_req_d;
  logic                start_btn_q, start_btn_d;
  logic                jump_btn_q, jump_btn_d;
  logic                menu_q, menu_d;
  logic                won_q, won_d;
  logic                lost_q, lost_d;

  logic                start_rise, jump_rise, hit_eff, jump_up;
  logic [10:0]         obj_sum, up_sum, down_diff;

`ifdef GAME_LIVES_EN
  logic [1:0]          lives_q, lives_d;
  logic                hit_mask_q, hit_mask_d;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    jump_d        = jump_q;
    distance_d    = distance_q;
    obj_counter_d = obj_counter_q;
    laps_d        = laps_q;
    jump_req_d    = jump_req_q;
    start_btn_d   = bus.start_btn;
    jump_btn_d    = bus.jump_btn;

    start_rise = bus.start_btn & ~start_btn_q;
    jump_rise  = bus.jump_btn & ~jump_btn_q;

    obj_sum   = {1'b0, obj_counter_q} + SCROLL_STEP_W;
    up_sum    = {1'b0, distance_q} + JUMP_STEP_W;
    down_diff = {1'b0, distance_q} - JUMP_STEP_W;
    jump_up   = (jump_q == J_UP) || ((jump_q == J_IDLE) && jump_req_q);

`ifdef GAME_LIVES_EN
    lives_d    = lives_q;
    hit_mask_d = hit_mask_q & bus.hit;
    hit_eff    = bus.hit & ~hit_mask_q;
`else
    hit_eff    = bus.hit;
`endif

    case (state_q)
      ST_MENU: begin
        // A start press outranks any game_tick arriving in the same clock.
        if (start_rise) begin
          state_d       = ST_PLAY;
          jump_d        = J_IDLE;
          distance_d    = '0;
          obj_counter_d = '0;
          laps_d        = '0;
          jump_req_d    = 1'b0;
`ifdef GAME_LIVES_EN
          lives_d       = 2'(LIVES);
          hit_mask_d    = 1'b0;
`endif
        end
      end

      ST_PLAY: begin
        if (hit_eff) begin
`ifdef GAME_LIVES_EN
          if (lives_q > 2'd1) begin
            // Lose a life and restart the lap in place; the held hit is masked until released.
            lives_d       = lives_q - 2'd1;
            jump_d        = J_IDLE;
            distance_d    = '0;
            obj_counter_d = '0;
            jump_req_d    = 1'b0;
            hit_mask_d    = 1'b1;
          end else begin
            lives_d = 2'd0;
            state_d = ST_LOST;
          end
`else
          state_d = ST_LOST;
`endif
        end else if (bus.game_tick) begin
          jump_req_d = 1'b0;

          if (obj_sum >= SCROLL_WRAP_W) begin
            obj_counter_d = '0;
            laps_d        = laps_q + LAPS_W'(1);
            if (laps_d == LAPS_W'(WIN_LAPS)) begin
              state_d = ST_WON;
            end
          end else begin
            obj_counter_d = obj_sum[9:0];
          end

          // A pending request launches the jump on this tick, so the first step is taken now.
          if (jump_up) begin
            if (up_sum >= JUMP_HEIGHT_W) begin
              distance_d = JUMP_HEIGHT_W[9:0];
              jump_d     = J_DOWN;
            end else begin
              distance_d = up_sum[9:0];
              jump_d     = J_UP;
            end
          end else if (jump_q == J_DOWN) begin
            if (down_diff[10] || (down_diff == 11'd0)) begin
              distance_d = '0;
              jump_d     = J_IDLE;
            end else begin
              distance_d = down_diff[9:0];
            end
          end
        end else if (jump_rise && (jump_q == J_IDLE)) begin
          jump_req_d = 1'b1;
        end
      end

      ST_WON, ST_LOST: begin
        if (start_rise) begin
          state_d = ST_MENU;
        end
      end

      default: state_d = ST_MENU;
    endcase

    menu_d = (state_d == ST_MENU);
    won_d  = (state_d == ST_WON);
    lost_d = (state_d == ST_LOST);
  end

  // NOTE: reset is synchronous and sampled only on the clock edge, so it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= ST_MENU;
      jump_q        <= J_IDLE;
      distance_q    <= '0;
      obj_counter_q <= '0;
      laps_q        <= '0;
      jump_req_q    <= 1'b0;
      start_btn_q   <= 1'b0;
      jump_btn_q    <= 1'b0;
      menu_q        <= 1'b1;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      jump_q        <= jump_d;
      distance_q    <= distance_d;
      obj_counter_q <= obj_counter_d;
      laps_q        <= laps_d;
      jump_req_q    <= jump_req_d;
      start_btn_q   <= start_btn_d;
      jump_btn_q    <= jump_btn_d;
      menu_q        <= menu_d;
      won_q         <= won_d;
      lost_q        <= lost_d;
    end
  end

`ifdef GAME_LIVES_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lives_q    <= 2'(LIVES);
      hit_mask_q <= 1'b0;
    end else begin
      lives_q    <= lives_d;
      hit_mask_q <= hit_mask_d;
    end
  end

  assign bus.lives_left = lives_q;
`else
  assign bus.lives_left = 2'(LIVES);
`endif

  assign bus.distance    = distance_q;
  assign bus.obj_counter = obj_counter_q;
  assign bus.menuScreen  = menu_q;
  assign bus.playerWon   = won_q;
  assign bus.playerLost  = lost_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: each check() compares the registered outputs
// right after the clock edge against hand-computed expectations.
module tb_game_state_ctrl;

  localparam int LIVES = 3;
  localparam logic [2:0] F_MENU = 3'b100;
  localparam logic [2:0] F_PLAY = 3'b000;
  localparam logic [2:0] F_WON  = 3'b010;
  localparam logic [2:0] F_LOST = 3'b001;
  // enable bits: [3] distance, [2] obj_counter, [1] flags, [0] lives
  localparam logic [3:0] EN_ALL   = 4'b1111;
  localparam logic [3:0] EN_FLAGS = 4'b0010;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    total = 0;
  int    bad   = 0;

  game_state_ctrl_if bus();

  game_state_ctrl #(
    .JUMP_HEIGHT(80), .JUMP_STEP(4), .SCROLL_STEP(2),
    .SCROLL_WRAP(800), .WIN_LAPS(3), .LIVES(LIVES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int d, input int o,
                       input logic [2:0] f, input int l, input logic [3:0] en);
    logic [9:0] exp_dist;
    logic [9:0] exp_obj;
    logic [1:0] exp_lives;
    logic [2:0] act_flags;
    logic       ok;
    exp_dist  = 10'(d);
    exp_obj   = 10'(o);
    exp_lives = 2'(l);
    act_flags = {bus.menuScreen, bus.playerWon, bus.playerLost};
    ok        = 1'b1;
    total++;
    if (en[3] && (bus.distance !== exp_dist)) begin
      ok = 1'b0;
      $display("FAIL %s: distance got %0d want %0d", nm, bus.distance, exp_dist);
    end
    if (en[2] && (bus.obj_counter !== exp_obj)) begin
      ok = 1'b0;
      $display("FAIL %s: obj_counter got %0d want %0d", nm, bus.obj_counter, exp_obj);
    end
    if (en[1] && (act_flags !== f)) begin
      ok = 1'b0;
      $display("FAIL %s: flags(m,w,l) got %b want %b", nm, act_flags, f);
    end
    if (en[0] && (bus.lives_left !== exp_lives)) begin
      ok = 1'b0;
      $display("FAIL %s: lives_left got %0d want %0d", nm, bus.lives_left, exp_lives);
    end
    if (!ok) bad++;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    int exp_d;
    bus.game_tick = 1'b0;
    bus.start_btn = 1'b0;
    bus.jump_btn  = 1'b0;
    bus.hit       = 1'b0;

    // Reset and menu behaviour
    reset = 1'b1; cyc(); check("reset", 0, 0, F_MENU, LIVES, EN_ALL);
    reset = 1'b0; cyc(); check("menu_idle", 0, 0, F_MENU, LIVES, EN_ALL);
    bus.game_tick = 1'b1; cyc(); check("menu_tick_ignored", 0, 0, F_MENU, LIVES, EN_ALL);
    bus.hit = 1'b1; cyc(); check("menu_hit_ignored", 0, 0, F_MENU, LIVES, EN_ALL);
    bus.hit = 1'b0;
    bus.start_btn = 1'b1; cyc(); check("start_beats_tick", 0, 0, F_PLAY, LIVES, EN_ALL);
    bus.start_btn = 1'b0; bus.game_tick = 1'b0;
    cyc(); check("play_idle", 0, 0, F_PLAY, LIVES, EN_ALL);

    // Jump arc with a dropped mid-air press
    bus.jump_btn = 1'b1; cyc(); check("jump_press", 0, 0, F_PLAY, LIVES, EN_ALL);
    bus.jump_btn = 1'b0;
    t = 0;
    for (int i = 1; i <= 41; i++) begin
      bus.game_tick = 1'b1; cyc(); t++;
      exp_d = (i <= 20) ? 4 * i : ((i <= 40) ? 80 - 4 * (i - 20) : 0);
      check("jump_arc", exp_d, (2 * t) % 800, F_PLAY, LIVES, EN_ALL);
      bus.game_tick = 1'b0;
      if (i == 10) begin
        bus.jump_btn = 1'b1; cyc(); check("jump_midair", 40, 2 * t, F_PLAY, LIVES, EN_ALL);
        bus.jump_btn = 1'b0; cyc(); check("jump_midair_rel", 40, 2 * t, F_PLAY, LIVES, EN_ALL);
      end
    end

    // Scroll through three laps to WON
    while (t < 1200) begin
      bus.game_tick = 1'b1; cyc(); t++;
      if (t < 1200) check("scroll", 0, (2 * t) % 800, F_PLAY, LIVES, EN_ALL);
      else          check("win_third_lap", 0, 0, F_WON, LIVES, EN_ALL);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); check("won_frozen", 0, 0, F_WON, LIVES, EN_ALL);
    end
    bus.hit = 1'b1; cyc(); check("won_hit_ignored", 0, 0, F_WON, LIVES, EN_ALL);
    bus.hit = 1'b0; bus.game_tick = 1'b0;
    bus.start_btn = 1'b1; cyc(); check("won_to_menu", 0, 0, F_MENU, LIVES, EN_ALL);
    bus.start_btn = 1'b0; cyc(); check("menu_again", 0, 0, F_MENU, LIVES, EN_ALL);

`ifndef GAME_LIVES_EN
    // Hit ends the game with the scroll position frozen
    bus.start_btn = 1'b1; cyc(); check("start_game2", 0, 0, F_PLAY, LIVES, EN_ALL);
    bus.start_btn = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      bus.game_tick = 1'b1; cyc(); check("scroll_game2", 0, 2 * i, F_PLAY, LIVES, EN_ALL);
    end
    bus.game_tick = 1'b0;
    bus.hit = 1'b1; cyc(); check("hit_lost", 0, 100, F_LOST, LIVES, EN_ALL);
    bus.game_tick = 1'b1; cyc(); check("lost_tick_frozen", 0, 100, F_LOST, LIVES, EN_ALL);
    bus.hit = 1'b0; cyc(); check("lost_frozen", 0, 100, F_LOST, LIVES, EN_ALL);
    bus.game_tick = 1'b0;
    bus.jump_btn = 1'b1; cyc(); check("lost_jump_ignored", 0, 100, F_LOST, LIVES, EN_ALL);
    bus.jump_btn = 1'b0;
    bus.start_btn = 1'b1; cyc(); check("lost_to_menu", 0, 100, F_MENU, LIVES, EN_ALL);
    bus.start_btn = 1'b0; cyc(); check("menu_holds_obj", 0, 100, F_MENU, LIVES, EN_ALL);
    bus.start_btn = 1'b1; cyc(); check("start_game3", 0, 0, F_PLAY, LIVES, EN_ALL);
    bus.start_btn = 1'b0;

    // Hit on the winning tick: LOST takes priority
    t = 0;
    for (int i = 1; i <= 1199; i++) begin
      bus.game_tick = 1'b1; cyc(); t++;
      check("scroll_game3", 0, (2 * t) % 800, F_PLAY, LIVES, EN_ALL);
    end
    bus.hit = 1'b1; cyc(); check("hit_and_win", 0, 0, F_LOST, LIVES, EN_FLAGS);
    bus.hit = 1'b0; bus.game_tick = 1'b0;
    bus.start_btn = 1'b1; cyc(); check("lost_to_menu2", 0, 0, F_MENU, LIVES, EN_FLAGS);
    bus.start_btn = 1'b0; cyc();
    bus.start_btn = 1'b1; cyc(); check("start_game4", 0, 0, F_PLAY, LIVES, EN_ALL);
    bus.start_btn = 1'b0; cyc();

    // Reset mid-jump
    bus.jump_btn = 1'b1; cyc(); bus.jump_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.game_tick = 1'b1; cyc(); check("jump_game4", 4 * i, 2 * i, F_PLAY, LIVES, EN_ALL);
    end
    bus.game_tick = 1'b0;
    reset = 1'b1; cyc(); check("reset_midjump", 0, 0, F_MENU, LIVES, EN_ALL);
    reset = 1'b0; cyc(); check("after_reset", 0, 0, F_MENU, LIVES, EN_ALL);
`else
    // Multi-life mode
    bus.start_btn = 1'b1; cyc(); check("lives_start", 0, 0, F_PLAY, 3, EN_ALL);
    bus.start_btn = 1'b0;
    bus.jump_btn = 1'b1; cyc(); bus.jump_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.game_tick = 1'b1; cyc(); check("lives_jump", 4 * i, 2 * i, F_PLAY, 3, EN_ALL);
    end
    bus.game_tick = 1'b0;
    bus.hit = 1'b1; cyc(); check("hit1", 0, 0, F_PLAY, 2, EN_ALL);
    bus.game_tick = 1'b1; cyc(); check("hit1_masked", 0, 2, F_PLAY, 2, EN_ALL);
    bus.game_tick = 1'b0; bus.hit = 1'b0; cyc(); check("hit1_release", 0, 2, F_PLAY, 2, EN_ALL);
    bus.hit = 1'b1; cyc(); check("hit2", 0, 0, F_PLAY, 1, EN_ALL);
    cyc(); check("hit2_masked", 0, 0, F_PLAY, 1, EN_ALL);
    bus.hit = 1'b0; bus.game_tick = 1'b1; cyc(); check("lives_scroll", 0, 2, F_PLAY, 1, EN_ALL);
    bus.game_tick = 1'b0;
    bus.hit = 1'b1; cyc(); check("hit3_lost", 0, 2, F_LOST, 0, EN_ALL);
    bus.hit = 1'b0;
    bus.start_btn = 1'b1; cyc(); check("lives_menu", 0, 2, F_MENU, 0, EN_ALL);
    bus.start_btn = 1'b0; cyc();
    bus.start_btn = 1'b1; cyc(); check("lives_reload", 0, 0, F_PLAY, 3, EN_ALL);
    bus.start_btn = 1'b0;
`endif

    repeat (3) @(negedge clk);
    if (bad == 0) $display("PASS test done: total=%0d bad=%0d", total, bad);
    else          $display("FAIL test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
